// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle shared by the fetch requester, the data requester,
// the memory-port arbiter and the single-port unified memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Instruction-fetch requester
    logic                  iReq;
    logic [ADDR_WIDTH-1:0] iAddr;
    logic [DATA_WIDTH-1:0] iRdata;
    logic                  iValid;
    logic                  iStall;

    // Data-memory (lw/sw) requester
    logic                  dReq;
    logic                  dWE;
    logic [ADDR_WIDTH-1:0] dAddr;
    logic [DATA_WIDTH-1:0] dWdata;
    logic [DATA_WIDTH-1:0] dRdata;
    logic                  dValid;
    logic                  dStall;

    // Unified memory port
    logic                  memReq;
    logic                  memWE;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memWdata;
    logic [DATA_WIDTH-1:0] memRdata;
    logic                  memReady;

    // Arbiter view: consumes requests and memory responses
    modport slave (
        input  iReq, iAddr, dReq, dWE, dAddr, dWdata, memRdata, memReady,
        output iRdata, iValid, iStall, dRdata, dValid, dStall,
        output memReq, memWE, memAddr, memWdata
    );

    // Environment view: requesters plus memory
    modport master (
        output iReq, iAddr, dReq, dWE, dAddr, dWdata, memRdata, memReady,
        input  iRdata, iValid, iStall, dRdata, dValid, dStall,
        input  memReq, memWE, memAddr, memWdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port unified memory between instruction fetch and the
// data-memory stage. One access at a time: IDLE -> BUSY_x -> RESP_x -> IDLE.
// Data wins ties unless fetch has lost STARVE_LIMIT grants in a row.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    mem_port_arbiter_if.slave bus_if
);
    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP_I,
        RESP_D
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t                state_q;
    logic [3:0]            starve_cnt_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [DATA_WIDTH-1:0] i_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;

    logic                  fetch_starved;
    logic                  data_wins;
    logic                  i_valid;
    logic                  d_valid;

    // Grant decision taken in IDLE: data first, unless fetch is starved
    assign fetch_starved = bus_if.iReq && (starve_cnt_q == STARVE_MAX);
    assign data_wins     = bus_if.dReq && !fetch_starved;

    // Arbiter FSM: grants, holds the latched memory request, captures read data
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge and also clears the data
        // registers, so an access cut off mid-flight leaves no stale word behind.
        if (!rstn) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            // NOTE: every state register uses <= so all of them see the
            // pre-edge values of one another, whatever the statement order.
            unique case (state_q)
                IDLE: begin
                    if (data_wins) begin
                        state_q     <= BUSY_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus_if.dWE;
                        mem_addr_q  <= bus_if.dAddr;
                        mem_wdata_q <= bus_if.dWdata;
                        if (bus_if.iReq) begin
                            starve_cnt_q <= (starve_cnt_q < STARVE_MAX) ?
                                            starve_cnt_q + 4'd1 : STARVE_MAX;
                        end else begin
                            starve_cnt_q <= '0;
                        end
                    end else if (bus_if.iReq) begin
                        state_q      <= BUSY_I;
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= bus_if.iAddr;
                        starve_cnt_q <= '0;
                    end
                end
                BUSY_I: begin
                    if (bus_if.memReady) begin
                        state_q   <= RESP_I;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        i_rdata_q <= bus_if.memRdata;
                    end
                end
                BUSY_D: begin
                    if (bus_if.memReady) begin
                        state_q   <= RESP_D;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        // A store completes without touching the load result
                        if (!mem_we_q) begin
                            d_rdata_q <= bus_if.memRdata;
                        end
                    end
                end
                RESP_I, RESP_D: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Completion pulses: a requester that dropped its request while the
    // access was in flight has been flushed, so its result is discarded.
    assign i_valid = (state_q == RESP_I) && bus_if.iReq;
    assign d_valid = (state_q == RESP_D) && bus_if.dReq;

    assign bus_if.iValid   = i_valid;
    assign bus_if.dValid   = d_valid;
    assign bus_if.iStall   = bus_if.iReq & ~i_valid;
    assign bus_if.dStall   = bus_if.dReq & ~d_valid;
    assign bus_if.iRdata   = i_rdata_q;
    assign bus_if.dRdata   = d_rdata_q;
    assign bus_if.memReq   = mem_req_q;
    assign bus_if.memWE    = mem_we_q;
    assign bus_if.memAddr  = mem_addr_q;
    assign bus_if.memWdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: cycle vectors, corner-case
// sequences and a randomized run checked against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .bus_if(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    bit               mem_auto = 1'b0;
    bit               mem_rand = 1'b0;
    int               mem_lat  = 1;
    int               busy_cnt = 0;
    int               cur_lat  = 1;
    logic [31:0]      mem [logic [31:0]];

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1357};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return mem_default(a);
    endfunction

    always @(negedge clk) begin
        if (mem_auto) begin
            if (bus.memReq) begin
                if (busy_cnt == 0) cur_lat = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
                busy_cnt++;
                bus.memReady = (busy_cnt == cur_lat);
                if (bus.memReady && bus.memWE) begin
                    mem[bus.memAddr] = bus.memWdata;
                    bus.memRdata = $urandom;
                end else if (bus.memReady) begin
                    bus.memRdata = mem_rd(bus.memAddr);
                end else begin
                    bus.memRdata = $urandom;
                end
            end else begin
                busy_cnt     = 0;
                bus.memReady = 1'b0;
            end
        end
    end

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [31:0] da, input logic [31:0] dd);
        bus.iReq   = ir;
        bus.iAddr  = ia;
        bus.dReq   = dr;
        bus.dWE    = dw;
        bus.dAddr  = da;
        bus.dWdata = dd;
    endtask

    // ---------------- cycle vectors ----------------
    typedef struct {
        logic ir; logic [31:0] ia; logic dr; logic dw; logic [31:0] da; logic [31:0] dd;
        logic mr; logic [31:0] mrd;
        logic e_mreq; logic e_mwe; logic [31:0] e_maddr; logic [31:0] e_mwdata;
        logic e_iv; logic e_is; logic e_dv; logic e_ds;
        logic [31:0] e_ird; logic [31:0] e_drd;
    } vec_t;

    vec_t vecs [16];

    function automatic logic [133:0] outs();
        return {bus.memReq, bus.memWE, bus.memAddr, bus.memWdata,
                bus.iValid, bus.iStall, bus.dValid, bus.dStall, bus.iRdata, bus.dRdata};
    endfunction

    // ---------------- random-run model state ----------------
    logic        p_ir, p_dr, p_dw, prev_mreq;
    logic [31:0] p_ia, p_da, p_dd;
    int          sb_cnt;
    bit          out_pend, out_is_d, i_done, d_done;
    logic [31:0] exp_rd, last_d_rd;
    logic [31:0] sb [logic [31:0]];
    int          i_wait, d_wait, max_wait, n_valids, n_grants;

    function automatic logic [31:0] sb_rd(input logic [31:0] a);
        if (sb.exists(a)) return sb[a];
        return mem_default(a);
    endfunction

    initial begin
        int          iv_cnt;
        bit          got;
        logic [31:0] cap_rd, cap_addr;
        bit          grants [$];
        int          c;

        vecs[0]  = '{1, 32'h40, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0,                   0, 1, 0, 0, 0, 0};
        vecs[1]  = '{1, 32'h40, 0, 0, 0, 0, 0, 0,                   1, 0, 32'h40, 0,              0, 1, 0, 0, 0, 0};
        vecs[2]  = '{1, 32'h40, 0, 0, 0, 0, 1, 32'h20080005,        1, 0, 32'h40, 0,              0, 1, 0, 0, 0, 0};
        vecs[3]  = '{1, 32'h40, 0, 0, 0, 0, 0, 0,                   0, 0, 32'h40, 0,              1, 0, 0, 0, 32'h20080005, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h40, 0,              0, 0, 0, 0, 32'h20080005, 0};
        vecs[5]  = '{0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0, 0,       0, 0, 32'h40, 0,              0, 0, 0, 1, 32'h20080005, 0};
        vecs[6]  = '{0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0, 0,       1, 1, 32'h100, 32'hDEADBEEF,  0, 0, 0, 1, 32'h20080005, 0};
        vecs[7]  = '{0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 1, 32'h12345678, 1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 1, 32'h20080005, 0};
        vecs[8]  = '{0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0, 0,       0, 0, 32'h100, 32'hDEADBEEF,  0, 0, 1, 0, 32'h20080005, 0};
        vecs[9]  = '{0, 0, 1, 0, 32'h100, 0, 0, 0,                  0, 0, 32'h100, 32'hDEADBEEF,  0, 0, 0, 1, 32'h20080005, 0};
        vecs[10] = '{0, 0, 1, 0, 32'h100, 0, 0, 0,                  1, 0, 32'h100, 0,             0, 0, 0, 1, 32'h20080005, 0};
        vecs[11] = '{0, 0, 1, 0, 32'h100, 0, 1, 32'hDEADBEEF,       1, 0, 32'h100, 0,             0, 0, 0, 1, 32'h20080005, 0};
        vecs[12] = '{0, 0, 1, 0, 32'h100, 0, 0, 0,                  0, 0, 32'h100, 0,             0, 0, 1, 0, 32'h20080005, 32'hDEADBEEF};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h100, 0,             0, 0, 0, 0, 32'h20080005, 32'hDEADBEEF};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF,             0, 0, 32'h100, 0,             0, 0, 0, 0, 32'h20080005, 32'hDEADBEEF};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h100, 0,             0, 0, 0, 0, 32'h20080005, 32'hDEADBEEF};

        // Reset state
        drive(0, 0, 0, 0, 0, 0);
        bus.memReady = 1'b0;
        bus.memRdata = '0;
        repeat (2) @(negedge clk);
        #1 check("reset_outputs", outs(), '0);

        // Single fetch, store/load, spurious memReady in IDLE
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            rstn = 1'b1;
            drive(vecs[k].ir, vecs[k].ia, vecs[k].dr, vecs[k].dw, vecs[k].da, vecs[k].dd);
            bus.memReady = vecs[k].mr;
            bus.memRdata = vecs[k].mrd;
            #1 check($sformatf("vec%0d", k), outs(),
                     {vecs[k].e_mreq, vecs[k].e_mwe, vecs[k].e_maddr, vecs[k].e_mwdata,
                      vecs[k].e_iv, vecs[k].e_is, vecs[k].e_dv, vecs[k].e_ds,
                      vecs[k].e_ird, vecs[k].e_drd});
        end

        // Flush: fetch dropped while its access is in flight, pending load served next
        @(negedge clk);
        mem_auto = 1'b1; mem_rand = 1'b0; mem_lat = 2;
        drive(1, 32'h200, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 1, 0, 32'h300, 0);
        iv_cnt = 0; got = 1'b0; cap_rd = '0; cap_addr = '0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            #1;
            if (bus.iValid) iv_cnt++;
            if (bus.dValid) begin
                got = 1'b1; cap_rd = bus.dRdata; cap_addr = bus.memAddr;
            end
        end
        check("flush_no_ivalid", iv_cnt, 0);
        check("flush_dvalid_seen", got, 1);
        check("flush_load_addr", cap_addr, 32'h300);
        check("flush_load_data", cap_rd, mem_default(32'h300));
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);

        // Reset in the middle of a data access
        @(negedge clk);
        mem_lat = 6;
        drive(0, 0, 1, 1, 32'h400, 32'hCAFEF00D);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            #1 if (bus.memReq) got = 1'b1;
        end
        check("rst_busy_reached", got, 1);
        @(negedge clk);
        rstn = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1 check("rst_mid_access", outs(), '0);
        @(negedge clk);
        rstn = 1'b1; mem_lat = 1;
        drive(1, 32'h500, 0, 0, 0, 0);
        got = 1'b0; cap_addr = '0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            #1;
            if (bus.memReq) cap_addr = bus.memAddr;
            if (bus.iValid) begin got = 1'b1; cap_rd = bus.iRdata; end
        end
        check("post_rst_ivalid", got, 1);
        check("post_rst_addr", cap_addr, 32'h500);
        check("post_rst_idata", cap_rd, mem_default(32'h500));
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);

        // Contention with both requests held: starvation counter forces fetch
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        drive(1, 32'h600, 1, 0, 32'h700, 0);
        prev_mreq = 1'b0;
        for (int n = 0; n < 200 && grants.size() < 10; n++) begin
            @(negedge clk);
            #1;
            if (bus.memReq && !prev_mreq) grants.push_back(bus.memAddr == 32'h600);
            prev_mreq = bus.memReq;
        end
        check("contention_grant_count", grants.size(), 10);
        c = 0;
        for (int g = 0; g < grants.size(); g++) begin
            bit exp_i;
            exp_i = (c == LIMIT);
            c = exp_i ? 0 : c + 1;
            check($sformatf("contention_grant%0d_is_fetch", g), grants[g], exp_i);
        end

        // Randomized traffic against a transaction-level model
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        mem.delete(); sb.delete();
        mem_rand = 1'b1;
        p_ir = 0; p_dr = 0; p_dw = 0; p_ia = 0; p_da = 0; p_dd = 0; prev_mreq = 0;
        sb_cnt = 0; out_pend = 0; out_is_d = 0; i_done = 0; d_done = 0;
        exp_rd = 0; last_d_rd = 0; i_wait = 0; d_wait = 0; max_wait = 0;
        n_valids = 0; n_grants = 0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if (i_done) begin
                i_done = 0;
                bus.iReq = 1'($urandom_range(0, 1));
                bus.iAddr = 32'($urandom_range(0, 15)) << 2;
                i_wait = 0;
            end else if (!bus.iReq && $urandom_range(0, 2) == 0) begin
                bus.iReq = 1'b1;
                bus.iAddr = 32'($urandom_range(0, 15)) << 2;
                i_wait = 0;
            end
            if (d_done) begin
                d_done = 0;
                bus.dReq = 1'($urandom_range(0, 1));
                bus.dWE = 1'($urandom_range(0, 1));
                bus.dAddr = 32'($urandom_range(0, 15)) << 2;
                bus.dWdata = $urandom;
                d_wait = 0;
            end else if (!bus.dReq && $urandom_range(0, 2) == 0) begin
                bus.dReq = 1'b1;
                bus.dWE = 1'($urandom_range(0, 1));
                bus.dAddr = 32'($urandom_range(0, 15)) << 2;
                bus.dWdata = $urandom;
                d_wait = 0;
            end
            #1;
            if (bus.memReq && !prev_mreq) begin
                bit exp_d;
                n_grants++;
                exp_d = p_dr && !(p_ir && sb_cnt == LIMIT);
                check("rnd_no_double_grant", out_pend, 0);
                if (exp_d) begin
                    check("rnd_grant_data", {bus.memWE, bus.memAddr, bus.memWdata}, {p_dw, p_da, p_dd});
                    sb_cnt = p_ir ? ((sb_cnt < LIMIT) ? sb_cnt + 1 : sb_cnt) : 0;
                    if (p_dw) begin
                        sb[p_da] = p_dd;
                        exp_rd = last_d_rd;
                    end else begin
                        exp_rd = sb_rd(p_da);
                    end
                end else begin
                    check("rnd_grant_fetch", {p_ir, bus.memWE, bus.memAddr}, {1'b1, 1'b0, p_ia});
                    sb_cnt = 0;
                    exp_rd = sb_rd(p_ia);
                end
                out_pend = 1; out_is_d = exp_d;
            end
            if (bus.iValid) begin
                check("rnd_ivalid_owner", {out_pend, out_is_d}, 2'b10);
                check("rnd_irdata", bus.iRdata, exp_rd);
                out_pend = 0; i_done = 1; n_valids++;
            end
            if (bus.dValid) begin
                check("rnd_dvalid_owner", {out_pend, out_is_d}, 2'b11);
                check("rnd_drdata", bus.dRdata, exp_rd);
                last_d_rd = exp_rd;
                out_pend = 0; d_done = 1; n_valids++;
            end
            if (bus.iReq && !i_done) i_wait++;
            if (bus.dReq && !d_done) d_wait++;
            if (i_wait > max_wait) max_wait = i_wait;
            if (d_wait > max_wait) max_wait = d_wait;
            p_ir = bus.iReq; p_ia = bus.iAddr;
            p_dr = bus.dReq; p_dw = bus.dWE; p_da = bus.dAddr; p_dd = bus.dWdata;
            prev_mreq = bus.memReq;
        end
        check("rnd_wait_bounded", max_wait <= 40, 1);
        check("rnd_valids_match_grants", n_valids + int'(out_pend), n_grants);
        check("rnd_made_progress", n_valids > 100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
